// File: rtl/window_gen7.sv
// window_gen7
//   Raster-to-window front end for the 7x7 spatial filter. Accepts one pixel
//   per cycle in raster order, keeps the previous MASK_WIDTH-1 lines in a
//   line memory, and presents a MASK_WIDTH x MASK_WIDTH window on p.
//
// Ports
//   clk        single clock, rising edge
//   reset_in   synchronous active-high reset
//   pix_in     unsigned input pixel
//   pix_valid  pix_in accepted this cycle
//   sof        start of frame (qualified by pix_valid), pixel is (0,0)
//   p          window, slice i = r*MASK_WIDTH+c; r=0 oldest line, c=0 oldest column
//   enable     one-cycle pulse: p holds a fully-interior window
//   win_last   with enable on the last window of the frame
//
// Pipeline: input capture -> stage 1 (counters, line read, flags)
//           -> stage 2 (window shift, line write-back, outputs).
//   A pixel sampled at edge N is reflected on p/enable/win_last after edge N+2.
module window_gen7 #(
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                    clk,
  input  logic                                    reset_in,
  input  logic [PIX_BIT-1:0]                      pix_in,
  input  logic                                    pix_valid,
  input  logic                                    sof,
  output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p,
  output logic                                    enable,
  output logic                                    win_last
);

  localparam int LINES = MASK_WIDTH - 1;
  localparam int XW    = $clog2(IMG_WIDTH);
  localparam int YW    = $clog2(IMG_HEIGHT);
  localparam int COLW  = PIX_BIT * LINES;

  // ---------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------
  logic               in_valid;
  logic               in_sof;
  logic [PIX_BIT-1:0] in_pix;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      in_valid <= 1'b0;
      in_sof   <= 1'b0;
    end else begin
      in_valid <= pix_valid;
      in_sof   <= pix_valid & sof;
    end
    if (pix_valid) begin
      in_pix <= pix_in;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: raster position, line memory read, window flags
  // ---------------------------------------------------------------------
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [XW-1:0]      cur_x;
  logic [YW-1:0]      cur_y;
  logic               cur_win;
  logic               cur_last;

  logic               s1_valid;
  logic               s1_win;
  logic               s1_last;
  logic [XW-1:0]      s1_x;
  logic [PIX_BIT-1:0] s1_pix;

  // sof overrides the running counters for the pixel that carries it
  always_comb begin
    cur_x    = in_sof ? '0 : x;
    cur_y    = in_sof ? '0 : y;
    cur_win  = (cur_x >= XW'(LINES)) && (cur_y >= YW'(LINES));
    cur_last = cur_win && (cur_x == XW'(IMG_WIDTH - 1)) &&
               (cur_y == YW'(IMG_HEIGHT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      x        <= '0;
      y        <= '0;
      s1_valid <= 1'b0;
      s1_win   <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_win  <= cur_win;
        s1_last <= cur_last;
        if (cur_x == XW'(IMG_WIDTH - 1)) begin
          x <= '0;
          y <= (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + YW'(1);
        end else begin
          x <= cur_x + XW'(1);
          y <= cur_y;
        end
      end else begin
        s1_win  <= 1'b0;
        s1_last <= 1'b0;
      end
    end
    if (in_valid) begin
      s1_x   <= cur_x;
      s1_pix <= in_pix;
    end
  end

  // ---------------------------------------------------------------------
  // Line memory: one word per column, lane j holds line y-LINES+j
  // (lane 0 oldest). Read-first; read and write-back of the same column
  // are always at least IMG_WIDTH accepted pixels apart.
  // ---------------------------------------------------------------------
  logic [COLW-1:0] line_mem [IMG_WIDTH];
  logic [COLW-1:0] rd_col;

  always_ff @(posedge clk) begin
    if (!reset_in && in_valid) begin
      rd_col <= line_mem[cur_x];
    end
    if (!reset_in && s1_valid) begin
      // drop the oldest lane, append the new pixel as the youngest line
      line_mem[s1_x] <= {s1_pix, rd_col[COLW-1:PIX_BIT]};
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: window shift array and outputs
  // ---------------------------------------------------------------------
  logic [PIX_BIT-1:0] win [MASK_WIDTH][MASK_WIDTH];

  always_ff @(posedge clk) begin
    if (reset_in) begin
      enable   <= 1'b0;
      win_last <= 1'b0;
      for (int unsigned r = 0; r < MASK_WIDTH; r++) begin
        for (int unsigned c = 0; c < MASK_WIDTH; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      enable   <= s1_valid & s1_win;
      win_last <= s1_valid & s1_last;
      if (s1_valid) begin
        for (int unsigned r = 0; r < MASK_WIDTH; r++) begin
          for (int unsigned c = 0; c < MASK_WIDTH - 1; c++) begin
            win[r][c] <= win[r][c+1];
          end
        end
        for (int unsigned r = 0; r < LINES; r++) begin
          win[r][MASK_WIDTH-1] <= rd_col[PIX_BIT*r +: PIX_BIT];
        end
        win[MASK_WIDTH-1][MASK_WIDTH-1] <= s1_pix;
      end
    end
  end

  always_comb begin
    p = '0;
    for (int unsigned r = 0; r < MASK_WIDTH; r++) begin
      for (int unsigned c = 0; c < MASK_WIDTH; c++) begin
        p[PIX_BIT*(r*MASK_WIDTH+c) +: PIX_BIT] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_gen7.sv
// Bench for window_gen7 on a 10x8 frame, pixel value = offset + 10*y + x.
// A frame-image model predicts every window; a per-cycle compare process
// checks enable/win_last/p, and each scenario pins the model with literals.
module tb_window_gen7;
  localparam int PB = 8;
  localparam int MW = 7;
  localparam int W  = 10;
  localparam int H  = 8;
  localparam int NS = MW * MW;
  localparam int PW = PB * NS;

  logic          clk = 1'b0;
  logic          reset_in;
  logic [PB-1:0] pix_in;
  logic          pix_valid;
  logic          sof;
  logic [PW-1:0] p;
  logic          enable;
  logic          win_last;

  always #5 clk = ~clk;

  window_gen7 #(
    .PIX_BIT   (PB),
    .MASK_WIDTH(MW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .sof      (sof),
    .p        (p),
    .enable   (enable),
    .win_last (win_last)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_p(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PB-1:0] sl(input logic [PW-1:0] v, input int i);
    return v[PB*i +: PB];
  endfunction

  // ---------------- model ----------------
  typedef struct {
    int            due;
    bit            last;
    logic [PW-1:0] win;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   mx = 0, my = 0, ek = 0;
  bit   rst_seen = 0;

  always @(posedge clk) begin
    exp_t e;
    ek++;
    if (reset_in) begin
      q.delete();
      mx = 0;
      my = 0;
      rst_seen = 1;
    end else if (pix_valid) begin
      if (sof) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = int'(pix_in);
      if (mx >= MW - 1 && my >= MW - 1) begin
        e.due  = ek + 2;
        e.last = (mx == W - 1) && (my == H - 1);
        for (int r = 0; r < MW; r++)
          for (int c = 0; c < MW; c++)
            e.win[PB*(r*MW+c) +: PB] = PB'(img[my-MW+1+r][mx-MW+1+c]);
        q.push_back(e);
      end
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  end

  // ---------------- compare + log ----------------
  logic [PW-1:0] log_p[$];
  bit            log_last[$];
  int            log_ek[$];

  always @(negedge clk) begin
    bit exp_en;
    if (rst_seen) begin
      chk_p("reset_p", p, '0);
      rst_seen = 0;
    end
    if (q.size() > 0 && q[0].due < ek) begin
      chk("window_overdue", 64'(ek), 64'(q[0].due));
      q.pop_front();
    end
    exp_en = (q.size() > 0) && (q[0].due == ek);
    chk("enable", enable, exp_en);
    if (exp_en) begin
      chk_p("window", p, q[0].win);
      chk("win_last", win_last, q[0].last);
      q.pop_front();
    end else begin
      chk("win_last_idle", win_last, 0);
    end
    if (enable === 1'b1) begin
      log_p.push_back(p);
      log_last.push_back(win_last);
      log_ek.push_back(ek);
    end
  end

  // ---------------- stimulus ----------------
  int accept66_ek = 0;
  logic [PW-1:0] basic[$];

  task automatic idle(input int n);
    repeat (n) begin
      pix_valid = 1'b0;
      sof       = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input int v, input bit s, input bit gapped, input int x, input int y);
    if (gapped && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    pix_valid = 1'b1;
    pix_in    = PB'(v);
    sof       = s;
    @(posedge clk);
    #1;
    if (x == 6 && y == 6) accept66_ek = ek;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic frame(input int off, input bit gapped, input int npix);
    for (int i = 0; i < npix; i++)
      px(off + 10 * (i / W) + (i % W), i == 0, gapped, i % W, i / W);
  endtask

  task automatic clear_log();
    log_p.delete();
    log_last.delete();
    log_ek.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    reset_in  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_enable", enable, 0);
    chk("reset_win_last", win_last, 0);
    chk_p("reset_p_init", p, '0);
    reset_in = 1'b0;

    // basic window packing
    clear_log();
    frame(0, 0, W * H);
    idle(4);
    chk("s1_count", log_p.size(), 8);
    if (log_p.size() == 8) begin
      chk("s1_latency", 64'(log_ek[0] - accept66_ek), 2);
      chk("s1_slice0", sl(log_p[0], 0), 0);
      chk("s1_slice24", sl(log_p[0], 24), 33);
      chk("s1_slice48", sl(log_p[0], 48), 66);
      chk("s1_final_slice48", sl(log_p[7], 48), 79);
      for (int i = 0; i < 8; i++)
        chk("s1_last_only_79", log_last[i], sl(log_p[i], 48) == 8'd79);
    end
    basic = log_p;

    // gapped input
    clear_log();
    frame(0, 1, W * H);
    idle(4);
    chk("s2_count", log_p.size(), 8);
    if (log_p.size() == 8 && basic.size() == 8)
      for (int i = 0; i < 8; i++) chk_p("s2_same_as_basic", log_p[i], basic[i]);

    // two frames back-to-back
    clear_log();
    frame(0, 0, W * H);
    frame(100, 0, W * H);
    idle(4);
    chk("s3_count", log_p.size(), 16);
    if (log_p.size() == 16) begin
      chk("s3_f1_end_slice48", sl(log_p[7], 48), 79);
      chk("s3_f1_last", log_last[7], 1);
      chk("s3_f2_slice0", sl(log_p[8], 0), 100);
      chk("s3_f2_slice48", sl(log_p[8], 48), 166);
      chk("s3_f2_last", log_last[15], 1);
    end

    // mid-frame restart at (4,6)
    clear_log();
    frame(0, 0, 6 * W + 4);
    frame(100, 0, W * H);
    idle(4);
    chk("s4_count", log_p.size(), 8);
    if (log_p.size() == 8) begin
      chk("s4_latency", 64'(log_ek[0] - accept66_ek), 2);
      chk("s4_slice0", sl(log_p[0], 0), 100);
      chk("s4_slice48", sl(log_p[0], 48), 166);
    end

    // reset while windows are in flight in row 7
    frame(0, 0, 7 * W + 8);
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    chk("s5_enable_after_reset", enable, 0);
    chk_p("s5_p_after_reset", p, '0);
    clear_log();
    idle(3);
    chk("s5_no_stale_windows", log_p.size(), 0);
    frame(0, 0, W * H);
    idle(4);
    chk("s5_count", log_p.size(), 8);
    if (log_p.size() == 8 && basic.size() == 8)
      for (int i = 0; i < 8; i++) chk_p("s5_same_as_basic", log_p[i], basic[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
